imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
Write-side counterpart to the instruction fetch path. It accepts a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit uPower instruction words. It stores the words in its own instruction memory and exposes a word-indexed fetch port driven by the program counter. The fetch port stays gated until a complete program load has finished.

Parameters:
DEPTH, 16, number of 32-bit instruction words in the memory.
ADDR_W, 4, word address width; must equal clog2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
load_start  input  1  single-cycle pulse; begins or restarts a load.
in_valid  input  1  byte on in_data is valid.
in_data  input  8  program byte; the most significant byte of each word arrives first.
in_last  input  1  qualifies the final byte of the program; sampled with in_valid.
in_ready  output  1  loader can accept a byte this cycle.
program_counter  input  32  word index of the instruction to fetch.
instruction  output  32  fetched instruction word.
loading  output  1  high while in the LOAD state.
program_ready  output  1  high while in the DONE state.
word_count  output  ADDR_W+1  number of words written in the current or last load.
load_error  output  1  the last load ended on a partial word.

Behaviour:
- States: IDLE, LOAD, DONE.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; byte_cnt=0; wr_ptr=0; word_count=0; load_error=0; assembly register=0.
  - Memory contents are not reset.
  - Resulting outputs: in_ready=0, loading=0, program_ready=0, instruction=0.
- Reset mid-load aborts immediately. No partial word is written.
- load_start in any state:
  - Next state is LOAD.
  - Clear byte_cnt, wr_ptr, word_count, load_error and the assembly register.
  - program_ready drops on the following cycle.
- in_ready = (state==LOAD) && !load_start. A byte arriving in the same cycle as load_start is never accepted.
- A byte is accepted when in_valid && in_ready.
  - It is placed at bits [31-8*byte_cnt -: 8] of the assembly register.
  - byte_cnt increments modulo 4.
- Word completion: when the accepted byte has byte_cnt==3, on that same edge:
  - mem[wr_ptr] is written with the full word.
  - wr_ptr and word_count each increment by 1.
  - There is no extra latency.
- in_last accepted with byte_cnt==3: the word is written, next state is DONE, load_error=0.
- in_last accepted with byte_cnt!=3:
  - The partial word is written to mem[wr_ptr], zero-padded in the unreceived low bytes.
  - word_count increments, load_error=1, next state is DONE.
- Full memory: when the write to word DEPTH-1 completes, next state is DONE regardless of in_last, with load_error=0.
  - In DONE, in_ready=0, so further bytes are back-pressured and never dropped silently.
- In IDLE and DONE, in_ready=0 and in_valid is ignored.
- Fetch port (combinational):
  - instruction = mem[program_counter[ADDR_W-1:0]] when program_ready=1 and program_counter < word_count.
  - Otherwise instruction=0. This covers out-of-range PC, PC upper bits set, IDLE and LOAD.
- word_count is held in DONE until the next load_start. load_error is held likewise.
- Edge cases:
  - A zero-length program is not possible; DONE is only reached via an accepted byte.
  - in_valid held high continuously gives one byte per cycle, i.e. 4 cycles per word.

Test Plan:
- Reset then pulse load_start; stream 8 bytes 7C,22,1A,14,38,40,00,05 with in_last on the 8th byte, one per cycle → word_count=2, program_ready=1, load_error=0; PC=0 gives 7C221A14, PC=1 gives 38400005, PC=2 gives 00000000.
- Random in_valid gaps with the same stream → identical memory contents; in_ready never drops in LOAD; loading=1 throughout.
- 6 bytes AA,BB,CC,DD,11,22 with in_last on the 6th → word_count=2, load_error=1, PC=1 gives 11220000.
- Stream 4*DEPTH+2 bytes without in_last → DONE after byte 64, word_count=16, in_ready=0 from the next cycle, last two bytes stalled.
- Assert load_start during byte 6 of a load, then send 4 bytes with in_last → word_count=1, the in-flight byte is not accepted (in_ready=0 that cycle), PC=0 gives the new word.
- Assert rst_n=0 mid-word, then release → all outputs at reset values, instruction=0, in_ready=0 until the next load_start.

Source files
------------

// File: rtl/imem_program_loader.sv
// Instruction memory program loader.
// Assembles a big-endian byte stream into 32-bit instruction words, stores
// them in a local memory and serves a PC-indexed fetch port once the load
// has finished.
module imem_program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [31:0]       program_counter,
  output logic [31:0]       instruction,
  output logic              loading,
  output logic              program_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              load_error
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       asm_word;
  logic [31:0]       word_next;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic              word_write;

  // A byte coinciding with load_start is refused so the restart is clean.
  assign in_ready      = (state == LOAD) && !load_start;
  assign accept        = in_valid && in_ready;
  assign word_write    = accept && ((byte_cnt == 2'd3) || in_last);
  assign loading       = (state == LOAD);
  assign program_ready = (state == DONE);

  // Merge the incoming byte into the assembly word, MSB first.
  always_comb begin
    word_next = asm_word;
    case (byte_cnt)
      2'd0:    word_next[31:24] = in_data;
      2'd1:    word_next[23:16] = in_data;
      2'd2:    word_next[15:8]  = in_data;
      default: word_next[7:0]   = in_data;
    endcase
  end

  // Load sequencing: state, byte position, write pointer, counters, error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      wr_ptr     <= '0;
      word_count <= '0;
      load_error <= 1'b0;
      asm_word   <= '0;
    end else if (load_start) begin
      state      <= LOAD;
      byte_cnt   <= 2'd0;
      wr_ptr     <= '0;
      word_count <= '0;
      load_error <= 1'b0;
      asm_word   <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      if (word_write) begin
        // Clearing here gives zero padding for a trailing partial word.
        asm_word   <= '0;
        wr_ptr     <= wr_ptr + 1'b1;
        word_count <= word_count + 1'b1;
        if (in_last) begin
          state      <= DONE;
          load_error <= (byte_cnt != 2'd3);
        end else if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
          state      <= DONE;
          load_error <= 1'b0;
        end
      end else begin
        asm_word <= word_next;
      end
    end
  end

  // Instruction storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (word_write) mem[wr_ptr] <= word_next;
  end

  // Fetch port, gated until a load has completed and bounded by word_count.
  always_comb begin
    instruction = '0;
    if (program_ready &&
        (program_counter < {{(31 - ADDR_W){1'b0}}, word_count}))
      instruction = mem[program_counter[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard testbench for imem_program_loader.
// Stimulus pushes expected observations into a queue and raises a probe
// strobe; a monitor pops and compares at the falling edge.
module tb_imem_program_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [31:0]       program_counter = 32'h0;
  logic [31:0]       instruction;
  logic              loading;
  logic              program_ready;
  logic [ADDR_W:0]   word_count;
  logic              load_error;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [4:0]  wc;
    logic        rdy;
    logic        err;
    logic        inr;
    logic        ld;
  } exp_t;

  exp_t sbq[$];
  logic probe_en = 1'b0;
  int   assert_count = 0;
  int   fail_count = 0;

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_start(load_start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .program_counter(program_counter),
    .instruction(instruction),
    .loading(loading),
    .program_ready(program_ready),
    .word_count(word_count),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s.%s: got %08h expected %08h", tag, field, act, exp);
    end
  endtask

  // Monitor: pops one expectation per probed cycle and compares all outputs.
  always @(negedge clk) begin
    if (probe_en) begin
      if (sbq.size() == 0) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL scoreboard: probe with empty queue, got 0 expected 1 entries");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_output(e.tag, "instruction", instruction, e.instr);
        check_output(e.tag, "word_count", 32'(word_count), 32'(e.wc));
        check_output(e.tag, "program_ready", 32'(program_ready), 32'(e.rdy));
        check_output(e.tag, "load_error", 32'(load_error), 32'(e.err));
        check_output(e.tag, "in_ready", 32'(in_ready), 32'(e.inr));
        check_output(e.tag, "loading", 32'(loading), 32'(e.ld));
      end
    end
  end

  // Called at posedge+1; occupies exactly one cycle.
  task automatic probe(input string tag, input logic [31:0] pc,
                       input logic [31:0] ei, input logic [4:0] wc,
                       input logic r, input logic e, input logic ir,
                       input logic ld);
    exp_t x;
    x.tag = tag; x.instr = ei; x.wc = wc;
    x.rdy = r; x.err = e; x.inr = ir; x.ld = ld;
    program_counter = pc;
    sbq.push_back(x);
    probe_en = 1'b1;
    @(posedge clk); #1;
    probe_en = 1'b0;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Offer one byte until accepted, bounded by a cycle budget.
  task automatic apply_stimulus(input logic [7:0] data, input logic last);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      assert_count++;
      fail_count++;
      $display("[TB] FAIL byte_accept: byte %02h got in_ready=0 expected 1 within budget", data);
    end
  endtask

  logic [7:0] prog_a [8] = '{8'h7C, 8'h22, 8'h1A, 8'h14, 8'h38, 8'h40, 8'h00, 8'h05};
  logic [7:0] prog_b [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
  logic [7:0] prog_c [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    probe("reset_held", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    probe("reset_idle", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two full words, back to back
    pulse_load_start();
    probe("loadA_start", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(prog_a[i], i == 7);
    probe("loadA_pc0", 32'h0, 32'h7C221A14, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    probe("loadA_pc1", 32'h1, 32'h38400005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    probe("loadA_pc2", 32'h2, 32'h00000000, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Same stream with idle gaps; in_ready and loading stay high in LOAD
    pulse_load_start();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(prog_a[i], i == 7);
      if (i != 7) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++)
          probe("gap", 32'h0, 32'h0, 5'((i + 1) / 4), 1'b0, 1'b0, 1'b1, 1'b1);
      end
    end
    probe("gapA_pc0", 32'h0, 32'h7C221A14, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    probe("gapA_pc1", 32'h1, 32'h38400005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    probe("gapA_pc2", 32'h2, 32'h00000000, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Partial trailing word
    pulse_load_start();
    probe("loadB_cleared", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) apply_stimulus(prog_b[i], i == 5);
    probe("loadB_pc0", 32'h0, 32'hAABBCCDD, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    probe("loadB_pc1", 32'h1, 32'h11220000, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    probe("loadB_pc_hi", 32'h80000001, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // Fill memory without in_last, then back-pressure two more bytes
    pulse_load_start();
    for (int i = 0; i < 4 * DEPTH; i++) begin
      logic [7:0] b;
      b = 8'(i);
      apply_stimulus(b, 1'b0);
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    probe("full_stall0", 32'h0, 32'h00010203, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    in_data  = 8'hEF;
    probe("full_stall1", 32'hF, 32'h3C3D3E3F, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    probe("full_pc16", 32'h10, 32'h0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    probe("full_pc7", 32'h7, 32'h1C1D1E1F, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart during byte 6; the coincident byte must be refused
    pulse_load_start();
    for (int i = 0; i < 5; i++) apply_stimulus(8'h50 + 8'(i), 1'b0);
    in_valid   = 1'b1;
    in_data    = 8'h99;
    load_start = 1'b1;
    probe("restart_cycle", 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    load_start = 1'b0;
    in_valid   = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(prog_c[i], i == 3);
    probe("restart_pc0", 32'h0, 32'hDEADBEEF, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    probe("restart_pc1", 32'h1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a word
    pulse_load_start();
    apply_stimulus(8'h12, 1'b0);
    apply_stimulus(8'h34, 1'b0);
    rst_n = 1'b0;
    #1;
    probe("midreset_held", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h56;
    probe("midreset_rel0", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    probe("midreset_rel1", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;

    // Drain and report
    for (int c = 0; c < 10 && sbq.size() != 0; c++) @(posedge clk);
    if (sbq.size() != 0) begin
      assert_count++;
      fail_count++;
      $display("[TB] FAIL scoreboard_drain: got %0d expected 0 pending entries", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
